rpc_cmd_arbiter: RTL and testbench



---
 rtl/rpc_config_path_pkg.sv | 14 +
 rtl/rpc_rr_pick.sv | 43 ++++
 rtl/rpc_cmd_arbiter.sv | 106 ++++++++++
 tb/tb_rpc_cmd_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpc_config_path_pkg.sv
// Shared types and default constants for the RPC controller configuration path.
package rpc_config_path_pkg;

  // Arbitration policy for the command merge stage
  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int unsigned RPC_ARB_NUM_SRC      = 4;
  localparam int unsigned RPC_REF_MAX_POSTPONE = 8;
  localparam int unsigned RPC_POSTPONE_W       = 8;

endpackage

// File: rtl/rpc_rr_pick.sv
// Wrap-around first-one finder: returns the first set request at or after
// start, wrapping modulo NUM_SRC. A start of 0 gives plain lowest-index priority.
module rpc_rr_pick #(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [2*NUM_SRC-1:0] req2;
  logic [NUM_SRC-1:0]   rot;
  logic [IDX_W-1:0]     off;
  logic [IDX_W:0]       sum;

  // Rotate the request vector so that bit 0 corresponds to the start index
  assign req2 = {req, req};
  assign rot  = NUM_SRC'(req2 >> start);

  // Find the lowest set bit of the rotated vector
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = IDX_W'(i);
      end
    end
  end

  // Map the rotated offset back to an absolute index, wrapping modulo NUM_SRC
  always_comb begin
    sum = {1'b0, start} + {1'b0, off};
    idx = sum[IDX_W-1:0];
    if (sum >= (IDX_W+1)'(NUM_SRC)) begin
      idx = IDX_W'(sum - (IDX_W+1)'(NUM_SRC));
    end
  end

endmodule

// File: rtl/rpc_cmd_arbiter.sv
// Merges NUM_SRC DRAM command streams into one registered command toward the
// PHY timing FSM. Fixed-priority or round-robin selection, with a starvation
// guard that promotes URGENT_SRC after MAX_POSTPONE lost arbitrations.
module rpc_cmd_arbiter
  import rpc_config_path_pkg::*;
#(
  parameter  int unsigned NUM_SRC      = RPC_ARB_NUM_SRC,
  parameter  int unsigned CMD_WIDTH    = 19,
  parameter  int unsigned URGENT_SRC   = 1,
  parameter  int unsigned MAX_POSTPONE = RPC_REF_MAX_POSTPONE,
  localparam int unsigned IDX_W        = $clog2(NUM_SRC)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         rr_mode_i,
  input  logic [NUM_SRC-1:0]           src_valid_i,
  input  logic [NUM_SRC*CMD_WIDTH-1:0] src_cmd_i,
  output logic [NUM_SRC-1:0]           src_ready_o,
  output logic                         cmd_valid_o,
  output logic [CMD_WIDTH-1:0]         cmd_o,
  output logic [IDX_W-1:0]             cmd_src_o,
  input  logic                         cmd_ready_i,
  output logic                         urgent_o,
  output logic [RPC_POSTPONE_W-1:0]    postpone_cnt_o
);

  localparam logic [IDX_W-1:0]          URG_IDX  = IDX_W'(URGENT_SRC);
  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(NUM_SRC - 1);
  localparam logic [RPC_POSTPONE_W-1:0] MAX_CNT  = RPC_POSTPONE_W'(MAX_POSTPONE);

  arb_mode_e            mode;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     ptr_next;
  logic [IDX_W-1:0]     start;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     win;
  logic                 pick_found;
  logic                 slot_free;
  logic                 urgent;
  logic                 grant;
  logic [CMD_WIDTH-1:0] cmds [NUM_SRC];

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_split
    assign cmds[k] = src_cmd_i[k*CMD_WIDTH +: CMD_WIDTH];
  end

  assign mode      = arb_mode_e'(rr_mode_i);
  assign urgent    = (postpone_cnt_o >= MAX_CNT);
  assign urgent_o  = urgent;
  assign slot_free = !cmd_valid_o || cmd_ready_i;
  assign start     = (mode == ARB_RR) ? ptr : '0;
  assign ptr_next  = (win == LAST_IDX) ? '0 : win + 1'b1;

  rpc_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req   (src_valid_i),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Winner selection; a promoted urgent source overrides the normal pick.
  // Grants are suppressed during reset so no source sees a ready that gets discarded.
  always_comb begin
    win         = (urgent && src_valid_i[URGENT_SRC]) ? URG_IDX : pick_idx;
    grant       = !rst_i && slot_free && pick_found;
    src_ready_o = '0;
    if (grant) begin
      src_ready_o[win] = 1'b1;
    end
  end

  // One-entry output register and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_valid_o <= 1'b0;
      cmd_o       <= '0;
      cmd_src_o   <= '0;
      ptr         <= '0;
    end else if (grant) begin
      cmd_valid_o <= 1'b1;
      cmd_o       <= cmds[win];
      cmd_src_o   <= win;
      if (mode == ARB_RR) begin
        ptr <= ptr_next;
      end
    end else if (cmd_ready_i) begin
      cmd_valid_o <= 1'b0;
    end
  end

  // Starvation guard: count grants lost by a waiting urgent source, saturating
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      postpone_cnt_o <= '0;
    end else if (grant) begin
      if (win == URG_IDX) begin
        postpone_cnt_o <= '0;
      end else if (src_valid_i[URGENT_SRC] && !urgent) begin
        postpone_cnt_o <= postpone_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rpc_cmd_arbiter.sv
// Directed bench for rpc_cmd_arbiter with a reference arbitration model and a
// scoreboard of granted commands checked when they appear at the output.
module tb_rpc_cmd_arbiter;

  localparam int NS   = 4;
  localparam int CW   = 19;
  localparam int URG  = 1;
  localparam int MAXP = 3;

  typedef struct {
    int            src;
    logic [CW-1:0] cmd;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            rr_mode;
  logic [NS-1:0]   src_valid;
  logic [NS*CW-1:0] src_cmd;
  logic [NS-1:0]   src_ready;
  logic            cmd_valid;
  logic [CW-1:0]   cmd;
  logic [1:0]      cmd_src;
  logic            cmd_ready;
  logic            urgent;
  logic [7:0]      postpone_cnt;

  bit   m_valid;
  int   m_ptr;
  int   m_cnt;
  exp_t sb[$];
  int   pend[NS];
  int   seq[NS];
  int   last_win;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rpc_cmd_arbiter #(
    .NUM_SRC      (NS),
    .CMD_WIDTH    (CW),
    .URGENT_SRC   (URG),
    .MAX_POSTPONE (MAXP)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rr_mode_i      (rr_mode),
    .src_valid_i    (src_valid),
    .src_cmd_i      (src_cmd),
    .src_ready_o    (src_ready),
    .cmd_valid_o    (cmd_valid),
    .cmd_o          (cmd),
    .cmd_src_o      (cmd_src),
    .cmd_ready_i    (cmd_ready),
    .urgent_o       (urgent),
    .postpone_cnt_o (postpone_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] cmd_of(input int k);
    return CW'((k << 12) | (seq[k] & 'hfff));
  endfunction

  task automatic apply();
    src_valid = {pend[3] > 0, pend[2] > 0, pend[1] > 0, pend[0] > 0};
    src_cmd   = {cmd_of(3), cmd_of(2), cmd_of(1), cmd_of(0)};
  endtask

  function automatic int model_win(input logic [NS-1:0] v, input logic rr,
                                   input int ptr, input int cnt);
    int s;
    int k;
    if (v == '0) return -1;
    if (cnt >= MAXP && v[URG]) return URG;
    s = rr ? ptr : 0;
    for (int i = 0; i < NS; i++) begin
      k = (s + i) % NS;
      if (v[2'(k)]) return k;
    end
    return -1;
  endfunction

  task automatic cycle();
    int            w;
    logic [NS-1:0] exp_rdy;
    exp_t          e;
    @(negedge clk);
    w = (!rst && (!m_valid || cmd_ready)) ? model_win(src_valid, rr_mode, m_ptr, m_cnt) : -1;
    exp_rdy = '0;
    if (w >= 0) exp_rdy[2'(w)] = 1'b1;
    check("src_ready", 32'(src_ready), 32'(exp_rdy));
    check("cmd_valid", 32'(cmd_valid), 32'(m_valid));
    check("urgent", 32'(urgent), (m_cnt >= MAXP) ? 32'd1 : 32'd0);
    check("postpone_cnt", 32'(postpone_cnt), 32'(m_cnt));
    if (m_valid) begin
      n_cmp++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL sb_empty observed=cmd_valid expected=no_output");
      end
      if (sb.size() > 0) begin
        e = sb[0];
        check("cmd_o", 32'(cmd), 32'(e.cmd));
        check("cmd_src", 32'(cmd_src), 32'(e.src));
        if (cmd_ready) void'(sb.pop_front());
      end
    end
    if (w >= 0) begin
      e.src = w;
      e.cmd = cmd_of(w);
      sb.push_back(e);
    end
    last_win = w;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      m_cnt   = 0;
      sb.delete();
    end else if (w >= 0) begin
      m_valid = 1'b1;
      if (rr_mode) m_ptr = (w + 1) % NS;
      if (w == URG) m_cnt = 0;
      else if (src_valid[URG] && m_cnt < MAXP) m_cnt++;
      seq[w]++;
      pend[w]--;
    end else if (cmd_ready) begin
      m_valid = 1'b0;
    end
    #1;
    apply();
  endtask

  initial begin
    rst       = 1'b1;
    rr_mode   = 1'b0;
    cmd_ready = 1'b0;
    for (int k = 0; k < NS; k++) begin
      pend[k] = 0;
      seq[k]  = 0;
    end
    m_valid  = 1'b0;
    m_ptr    = 0;
    m_cnt    = 0;
    last_win = -1;
    apply();
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_cmd_src", 32'(cmd_src), 32'd0);
    check("rst_src_ready", 32'(src_ready), 32'd0);
    check("rst_urgent", 32'(urgent), 32'd0);
    check("rst_postpone", 32'(postpone_cnt), 32'd0);
    rst = 1'b0;

    // Fixed priority, sources 1 and 3
    cmd_ready = 1'b1;
    pend[1] = 1;
    pend[3] = 1;
    apply();
    cycle();
    check("fix_first_src", 32'(cmd_src), 32'd1);
    cycle();
    check("fix_second_src", 32'(cmd_src), 32'd3);
    check("fix_second_valid", 32'(cmd_valid), 32'd1);
    repeat (2) cycle();

    // Round-robin, all sources valid
    rr_mode = 1'b1;
    for (int k = 0; k < NS; k++) pend[k] = 3;
    apply();
    for (int i = 0; i < 12; i++) begin
      cycle();
      check("rr_order", 32'(last_win), 32'(i % NS));
    end
    repeat (2) cycle();

    // Backpressure with a held command
    rr_mode = 1'b0;
    pend[0] = 2;
    pend[2] = 2;
    apply();
    cycle();
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_ready_low", 32'(src_ready), 32'd0);
      check("bp_hold_cmd", 32'(cmd), 32'(CW'(0 << 12)) | 32'(seq[0] - 1));
    end
    cmd_ready = 1'b1;
    repeat (5) cycle();

    // Mid-operation reset with ptr at 2 and a command held
    rr_mode = 1'b1;
    pend[0] = 1;
    pend[1] = 1;
    apply();
    repeat (2) cycle();
    check("pre_rst_src", 32'(cmd_src), 32'd1);
    cmd_ready = 1'b0;
    rst = 1'b1;
    pend[2] = 1;
    apply();
    cycle();
    check("mid_rst_valid", 32'(cmd_valid), 32'd0);
    check("mid_rst_cmd", 32'(cmd), 32'd0);
    check("mid_rst_src", 32'(cmd_src), 32'd0);
    check("mid_rst_ready", 32'(src_ready), 32'd0);
    check("mid_rst_postpone", 32'(postpone_cnt), 32'd0);
    rst = 1'b0;
    cmd_ready = 1'b1;
    pend[0] = 1;
    apply();
    cycle();
    check("post_rst_first", 32'(last_win), 32'd0);
    cycle();
    check("post_rst_second", 32'(last_win), 32'd2);
    cycle();

    // Mode switch with ptr retained at 3
    rr_mode = 1'b0;
    pend[0] = 1;
    pend[3] = 1;
    apply();
    cycle();
    check("sw_fixed_win", 32'(last_win), 32'd0);
    rr_mode = 1'b1;
    pend[0] = 1;
    apply();
    cycle();
    check("sw_rr_resume", 32'(last_win), 32'd3);
    cycle();
    check("sw_rr_next", 32'(last_win), 32'd0);
    cycle();

    // Starvation guard in fixed mode
    rr_mode = 1'b0;
    pend[0] = 8;
    pend[1] = 1;
    apply();
    for (int i = 0; i < MAXP; i++) begin
      cycle();
      check("starve_src0", 32'(last_win), 32'd0);
    end
    check("starve_urgent", 32'(urgent), 32'd1);
    check("starve_cnt", 32'(postpone_cnt), 32'(MAXP));
    cycle();
    check("starve_promoted", 32'(last_win), 32'(URG));
    check("starve_cleared", 32'(postpone_cnt), 32'd0);
    check("starve_urgent_off", 32'(urgent), 32'd0);
    pend[1] = 1;
    apply();
    repeat (2) cycle();
    pend[1] = 0;
    apply();
    repeat (2) cycle();
    check("hold_cnt", 32'(postpone_cnt), 32'd2);
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
